// File: rtl/ula8_acc_seq_if.sv
// rtl/ula8_acc_seq_if.sv - operation input handshake bundle for ula8_acc_seq
interface ula8_acc_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] b;

    modport master (output in_valid, output op, output b, input in_ready);
    modport slave  (input in_valid, input op, input b, output in_ready);
endinterface

// File: rtl/ula8_acc_seq.sv
// rtl/ula8_acc_seq.sv - accumulator/op sequencer with add/sub/logic ops and shift-add multiply
module ula8_acc_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    ula8_acc_seq_if.slave     in_if,
    output logic [WIDTH-1:0]  acc,
    output logic              c,
    output logic              z,
    output logic              v,
    output logic              out_valid,
    output logic              busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 c_q, c_d;
    logic                 z_q, z_d;
    logic                 v_q, v_d;
    logic                 ov_q, ov_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH:0]       add_sum;
    logic                 add_v;
    logic [2*WIDTH-1:0]   prod_step;
    logic                 mul_last;

    // SUB reuses the adder as acc + ~b + 1, so carry-out means "no borrow"
    always_comb begin
        add_b   = (in_if.op == OP_SUB) ? ~in_if.b : in_if.b;
        add_sum = {1'b0, acc_q} + {1'b0, add_b} + {{WIDTH{1'b0}}, (in_if.op == OP_SUB)};
        add_v   = (acc_q[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != acc_q[WIDTH-1]);
    end

    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
    assign mul_last  = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        c_d      = c_q;
        z_d      = z_q;
        v_d      = v_q;
        ov_d     = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_if.in_valid) begin
                    ov_d = 1'b1;
                    c_d  = 1'b0;
                    v_d  = 1'b0;
                    case (in_if.op)
                        OP_LOAD: acc_d = in_if.b;
                        OP_ADD, OP_SUB: begin
                            acc_d = add_sum[WIDTH-1:0];
                            c_d   = add_sum[WIDTH];
                            v_d   = add_v;
                        end
                        OP_AND:  acc_d = acc_q & in_if.b;
                        OP_OR:   acc_d = acc_q | in_if.b;
                        OP_NOT:  acc_d = ~acc_q;
                        OP_MUL: begin
                            // flags are held; with MUL disabled this is a pure no-op pulse
                            c_d = c_q;
                            v_d = v_q;
                            if (MUL_EN != 0) begin
                                ov_d     = 1'b0;
                                mcand_d  = {{WIDTH{1'b0}}, acc_q};
                                mplier_d = in_if.b;
                                prod_d   = '0;
                                cnt_d    = '0;
                                state_d  = S_MUL;
                            end
                        end
                        OP_CLR:  acc_d = '0;
                        default: acc_d = acc_q;
                    endcase
                    if (in_if.op != OP_MUL) begin
                        z_d = (acc_d == '0);
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (mul_last) begin
                    acc_d   = prod_step[WIDTH-1:0];
                    c_d     = |prod_step[2*WIDTH-1:WIDTH];
                    v_d     = 1'b0;
                    z_d     = (prod_step[WIDTH-1:0] == '0);
                    ov_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b1;
            v_q      <= 1'b0;
            ov_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            z_q      <= z_d;
            v_q      <= v_d;
            ov_q     <= ov_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_if.in_ready = (state_q == S_IDLE);
    assign busy           = (state_q == S_MUL);
    assign acc            = acc_q;
    assign c              = c_q;
    assign z              = z_q;
    assign v              = v_q;
    assign out_valid      = ov_q;
endmodule

// File: tb/tb_ula8_acc_seq.sv
// tb/tb_ula8_acc_seq.sv - scoreboard bench for ula8_acc_seq (MUL_EN=1 and MUL_EN=0 instances)
module tb_ula8_acc_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    ula8_acc_seq_if #(.WIDTH(8)) if0 ();
    ula8_acc_seq_if #(.WIDTH(8)) if1 ();

    logic [7:0] acc0, acc1;
    logic       c0, z0, v0, ov0, busy0;
    logic       c1, z1, v1, ov1, busy1;

    ula8_acc_seq #(.WIDTH(8), .MUL_EN(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_if(if0),
        .acc(acc0), .c(c0), .z(z0), .v(v0), .out_valid(ov0), .busy(busy0)
    );

    ula8_acc_seq #(.WIDTH(8), .MUL_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_if(if1),
        .acc(acc1), .c(c1), .z(z1), .v(v1), .out_valid(ov1), .busy(busy1)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] q0[$];
    logic [10:0] mon_exp;
    logic [7:0]  m_acc;

    // Reference model: returns {acc, c, z, v}
    function automatic logic [10:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] bv);
        int         s, sa, sb, p;
        logic [7:0] r;
        logic       cc, vv;
        cc = 1'b0;
        vv = 1'b0;
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = bv[7] ? int'(bv) - 256 : int'(bv);
        case (o)
            3'd0: r = bv;
            3'd1: begin
                s  = int'(a) + int'(bv);
                r  = s[7:0];
                cc = (s > 255);
                vv = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            3'd2: begin
                s  = int'(a) - int'(bv);
                r  = s[7:0];
                cc = (a >= bv);
                vv = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            3'd3: r = a & bv;
            3'd4: r = a | bv;
            3'd5: r = ~a;
            3'd6: begin
                p  = int'(a) * int'(bv);
                r  = p[7:0];
                cc = (p > 255);
            end
            default: r = 8'h00;
        endcase
        return {r, cc, (r == 8'h00), vv};
    endfunction

    always @(negedge clk) begin
        if (ov0 === 1'b1) begin
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_pulse acc=%h c=%b z=%b v=%b required no out_valid", acc0, c0, z0, v0);
            end else begin
                mon_exp = q0.pop_front();
                if ({acc0, c0, z0, v0} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_result got acc=%h czv=%b%b%b required acc=%h czv=%b", acc0, c0, z0, v0,
                             mon_exp[10:3], mon_exp[2:0]);
                end
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [7:0] bv);
        int          w;
        logic [10:0] r;
        w = 0;
        @(negedge clk);
        if0.in_valid = 1'b1;
        if0.op       = o;
        if0.b        = bv;
        while (if0.in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout in_ready=%b required 1", if0.in_ready);
        end else begin
            r = model(o, m_acc, bv);
            q0.push_back(r);
            m_acc = r[10:3];
        end
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        if0.in_valid = 1'b1;
        if0.op       = 3'd0;
        if0.b        = 8'hAA;
        if1.in_valid = 1'b1;
        if1.op       = 3'd0;
        if1.b        = 8'hAA;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({acc0, c0, z0, v0} !== {8'h00, 3'b010}) begin
            n_fail++;
            $display("FAIL reset_flags0 got acc=%h czv=%b%b%b required acc=00 czv=010", acc0, c0, z0, v0);
        end
        n_tests++;
        if ({ov0, busy0, if0.in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_ctrl0 got ov/busy/rdy=%b%b%b required 001", ov0, busy0, if0.in_ready);
        end
        n_tests++;
        if ({acc1, c1, z1, v1, ov1} !== {8'h00, 4'b0100}) begin
            n_fail++;
            $display("FAIL reset_dut1 got acc=%h czvo=%b%b%b%b required acc=00 czvo=0100", acc1, c1, z1, v1, ov1);
        end
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        rst_n        = 1'b1;
        m_acc        = 8'h00;
        @(negedge clk);
        n_tests++;
        if ({acc0, ov0, if0.in_ready} !== {8'h00, 2'b01}) begin
            n_fail++;
            $display("FAIL reset_release got acc=%h ov=%b rdy=%b required acc=00 ov=0 rdy=1", acc0, ov0, if0.in_ready);
        end
    endtask

    task automatic test_add_overflow();
        send(3'd0, 8'h7F);
        @(negedge clk);
        n_tests++;
        if (ov0 !== 1'b1) begin
            n_fail++;
            $display("FAIL load_pulse got out_valid=%b required 1", ov0);
        end
        send(3'd1, 8'h01);
        @(negedge clk);
        n_tests++;
        if ({ov0, acc0, c0, z0, v0} !== {1'b1, 8'h80, 3'b001}) begin
            n_fail++;
            $display("FAIL add_ovf got ov=%b acc=%h czv=%b%b%b required ov=1 acc=80 czv=001", ov0, acc0, c0, z0, v0);
        end
        @(negedge clk);
        n_tests++;
        if (ov0 !== 1'b0) begin
            n_fail++;
            $display("FAIL add_pulse_width got out_valid=%b required 0", ov0);
        end
    endtask

    task automatic test_sub();
        send(3'd0, 8'h05);
        send(3'd2, 8'h05);
        @(negedge clk);
        n_tests++;
        if ({acc0, c0, z0, v0} !== {8'h00, 3'b110}) begin
            n_fail++;
            $display("FAIL sub_equal got acc=%h czv=%b%b%b required acc=00 czv=110", acc0, c0, z0, v0);
        end
        send(3'd0, 8'h05);
        send(3'd2, 8'h06);
        @(negedge clk);
        n_tests++;
        if ({acc0, c0, z0, v0} !== {8'hFF, 3'b000}) begin
            n_fail++;
            $display("FAIL sub_borrow got acc=%h czv=%b%b%b required acc=FF czv=000", acc0, c0, z0, v0);
        end
    endtask

    task automatic test_mul();
        logic [10:0] r;
        send(3'd0, 8'h10);
        @(negedge clk);
        if0.in_valid = 1'b1;
        if0.op       = 3'd6;
        if0.b        = 8'h11;
        n_tests++;
        if (if0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_accept_ready got %b required 1", if0.in_ready);
        end
        r = model(3'd6, m_acc, 8'h11);
        q0.push_back(r);
        m_acc = r[10:3];
        @(posedge clk);
        #1;
        if0.op = 3'd0;
        if0.b  = 8'h55;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_tests++;
            if ({if0.in_ready, busy0, ov0, acc0} !== {3'b010, 8'h10}) begin
                n_fail++;
                $display("FAIL mul_busy_cycle%0d got rdy/busy/ov=%b%b%b acc=%h required 010 acc=10", i,
                         if0.in_ready, busy0, ov0, acc0);
            end
        end
        @(negedge clk);
        n_tests++;
        if ({if0.in_ready, busy0, ov0, acc0, c0, z0, v0} !== {3'b101, 8'h10, 3'b100}) begin
            n_fail++;
            $display("FAIL mul_done got rdy/busy/ov=%b%b%b acc=%h czv=%b%b%b required 101 acc=10 czv=100",
                     if0.in_ready, busy0, ov0, acc0, c0, z0, v0);
        end
        r = model(3'd0, m_acc, 8'h55);
        q0.push_back(r);
        m_acc = r[10:3];
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ov0, acc0} !== {1'b1, 8'h55}) begin
            n_fail++;
            $display("FAIL mul_held_load got ov=%b acc=%h required ov=1 acc=55", ov0, acc0);
        end
    endtask

    task automatic test_reset_mid_mul();
        send(3'd0, 8'h0F);
        @(negedge clk);
        if0.in_valid = 1'b1;
        if0.op       = 3'd6;
        if0.b        = 8'h03;
        @(posedge clk);
        #1 if0.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({busy0, acc0} !== {1'b1, 8'h0F}) begin
            n_fail++;
            $display("FAIL midmul_pre got busy=%b acc=%h required busy=1 acc=0F", busy0, acc0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({acc0, c0, z0, v0, ov0, busy0, if0.in_ready} !== {8'h00, 6'b010001}) begin
            n_fail++;
            $display("FAIL midmul_reset got acc=%h czv=%b%b%b ov/busy/rdy=%b%b%b required acc=00 czv=010 001",
                     acc0, c0, z0, v0, ov0, busy0, if0.in_ready);
        end
        rst_n = 1'b1;
        m_acc = 8'h00;
        repeat (10) @(negedge clk);
        n_tests++;
        if ({busy0, acc0} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL midmul_after got busy=%b acc=%h required busy=0 acc=00", busy0, acc0);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[4];
        logic [7:0]  bs[4];
        logic [7:0]  want[4];
        logic [10:0] r;
        ops  = '{3'd0, 3'd1, 3'd3, 3'd5};
        bs   = '{8'h03, 8'h04, 8'h06, 8'h00};
        want = '{8'h03, 8'h07, 8'h06, 8'hF9};
        @(negedge clk);
        if0.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if0.op = ops[i];
            if0.b  = bs[i];
            r = model(ops[i], m_acc, bs[i]);
            q0.push_back(r);
            m_acc = r[10:3];
            @(negedge clk);
            n_tests++;
            if ({ov0, acc0} !== {1'b1, want[i]}) begin
                n_fail++;
                $display("FAIL b2b_step%0d got ov=%b acc=%h required ov=1 acc=%h", i, ov0, acc0, want[i]);
            end
        end
        if0.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ov0, z0, c0} !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_end got ov=%b z=%b c=%b required 000", ov0, z0, c0);
        end
    endtask

    task automatic test_or_clr();
        send(3'd0, 8'hF0);
        send(3'd4, 8'h0F);
        @(negedge clk);
        n_tests++;
        if ({acc0, z0} !== {8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL or_result got acc=%h z=%b required acc=FF z=0", acc0, z0);
        end
        send(3'd7, 8'h5A);
        @(negedge clk);
        n_tests++;
        if ({acc0, c0, z0, v0} !== {8'h00, 3'b010}) begin
            n_fail++;
            $display("FAIL clr_result got acc=%h czv=%b%b%b required acc=00 czv=010", acc0, c0, z0, v0);
        end
    endtask

    task automatic test_mul_disabled();
        @(negedge clk);
        if1.in_valid = 1'b1;
        if1.op       = 3'd0;
        if1.b        = 8'h3C;
        @(posedge clk);
        #1;
        if1.op = 3'd1;
        if1.b  = 8'hE0;
        @(posedge clk);
        #1;
        if1.op = 3'd6;
        if1.b  = 8'h05;
        @(negedge clk);
        n_tests++;
        if ({ov1, acc1, c1, z1, v1} !== {1'b1, 8'h1C, 3'b100}) begin
            n_fail++;
            $display("FAIL nomul_add got ov=%b acc=%h czv=%b%b%b required ov=1 acc=1C czv=100", ov1, acc1, c1, z1, v1);
        end
        @(posedge clk);
        #1 if1.in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ov1, busy1, if1.in_ready, acc1, c1, z1, v1} !== {3'b101, 8'h1C, 3'b100}) begin
            n_fail++;
            $display("FAIL nomul_op got ov/busy/rdy=%b%b%b acc=%h czv=%b%b%b required 101 acc=1C czv=100",
                     ov1, busy1, if1.in_ready, acc1, c1, z1, v1);
        end
        @(negedge clk);
        n_tests++;
        if ({ov1, acc1} !== {1'b0, 8'h1C}) begin
            n_fail++;
            $display("FAIL nomul_after got ov=%b acc=%h required ov=0 acc=1C", ov1, acc1);
        end
    endtask

    initial begin
        if0.in_valid = 1'b0;
        if0.op       = 3'd0;
        if0.b        = 8'h00;
        if1.in_valid = 1'b0;
        if1.op       = 3'd0;
        if1.b        = 8'h00;
        m_acc        = 8'h00;
        test_reset();
        test_add_overflow();
        test_sub();
        test_mul();
        test_reset_mid_mul();
        test_back_to_back();
        test_or_clr();
        test_mul_disabled();
        repeat (3) @(negedge clk);
        n_tests++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending results required 0", q0.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
